// File: rtl/uart_rx_os.sv
// uart_rx_os: UART receiver with 16x-style oversampling.
//
// Recovers frames of one start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and one stop bit from an asynchronous serial line.
// Each bit is sampled near its midpoint. A start bit that is high again at
// its midpoint is discarded as a glitch. A low stop bit is reported as a
// framing error. A line held low after such a frame (a break) produces only
// that one report.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   rx         serial input, idles high, asynchronous to clk
//   rxout      last received data word, LSB = first data bit
//   rxdone     one-cycle strobe; rxout and the error flags are valid in this cycle
//   frame_err  stop bit was sampled low for the last frame
//   parity_err parity mismatch for the last frame (always 0 without parity)
//   busy       receiver is somewhere inside a frame (state not IDLE)
module uart_rx_os #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxout,
    output logic                 rxdone,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW       = $clog2(OVERSAMPLE);
    localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] HALF_LAST = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] FULL_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [OW-1:0]        os_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_err;

    // Two-flop synchronizer; it resets to the idle level so that leaving
    // reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Oversampling tick generator. Holding it at zero while idle aligns the
    // tick phase to the detected start edge of every frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign busy = (state != IDLE);

    // Frame state machine. os_cnt counts ticks within the current bit; the
    // start bit is checked after half a bit, after which every sample lands
    // one full bit later, i.e. at the middle of each following bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_acc    <= 1'b0;
            par_err    <= 1'b0;
            rxout      <= '0;
            rxdone     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rxdone <= 1'b0;
            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (os_cnt == HALF_LAST) begin
                            os_cnt  <= '0;
                            bit_idx <= '0;
                            par_acc <= 1'b0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (os_cnt == FULL_LAST) begin
                            os_cnt    <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            par_acc   <= par_acc ^ rx_s;
                            if (bit_idx == BIT_LAST) begin
                                state <= PAR_EN ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        if (os_cnt == FULL_LAST) begin
                            os_cnt  <= '0;
                            par_err <= par_acc ^ rx_s ^ PAR_ODD;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                // Leaving STOP at the stop-bit midpoint lets the next start
                // edge be caught even with no idle time between frames.
                STOP: begin
                    if (tick) begin
                        if (os_cnt == FULL_LAST) begin
                            os_cnt     <= '0;
                            rxdone     <= 1'b1;
                            rxout      <= shift_reg;
                            frame_err  <= ~rx_s;
                            parity_err <= PAR_EN & par_err;
                            state      <= rx_s ? IDLE : BREAK;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os.
//
// Two receivers share clock and reset: "dut" is plain 8N1 on line rx, and
// "dut_p" has even parity enabled on line rx_p. Frames are produced by a
// bit-timed line model (160 clocks per bit) and every received word is
// compared against the bytes the model sent.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;

    logic [7:0] rxout, rxout_p;
    logic       rxdone, rxdone_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;
    logic       busy, busy_p;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int dbl_strobes = 0;

    logic [7:0] q_data[$];
    bit         q_fe[$];
    bit         q_pe[$];
    int         q_cyc[$];
    logic [7:0] qp_data[$];
    bit         qp_pe[$];
    logic       prev_done = 1'b0;
    logic       prev_done_p = 1'b0;

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rxout(rxout), .rxdone(rxdone), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p),
        .rxout(rxout_p), .rxdone(rxdone_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed frame, sampled on the falling edge.
    always @(negedge clk) begin
        if (rxdone) begin
            q_data.push_back(rxout);
            q_fe.push_back(frame_err);
            q_pe.push_back(parity_err);
            q_cyc.push_back(cyc);
        end
        if (rxdone_p) begin
            qp_data.push_back(rxout_p);
            qp_pe.push_back(parity_err_p);
        end
        if ((rxdone && prev_done) || (rxdone_p && prev_done_p)) dbl_strobes++;
        prev_done   = rxdone;
        prev_done_p = rxdone_p;
    end

    task automatic drive_bit(input int line, input logic b, input int clocks);
        if (line == 0) rx = b; else rx_p = b;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send_frame(input int line, input logic [7:0] data, input bit with_par,
                              input logic pbit, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        drive_bit(line, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(line, data[i], BIT_CLKS);
        if (with_par) drive_bit(line, pbit, BIT_CLKS);
        drive_bit(line, stop_bit, BIT_CLKS);
    endtask

    task automatic clear_queues();
        q_data.delete(); q_fe.delete(); q_pe.delete(); q_cyc.delete();
        qp_data.delete(); qp_pe.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({rxout, rxdone, frame_err, parity_err, busy} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got rxout=%h done=%b fe=%b pe=%b busy=%b, want all 0",
                     rxout, rxdone, frame_err, parity_err, busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        int sc, delta;
        clear_queues();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, sc);
        repeat (40) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_count: got %0d rxdone, want 1", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 8'hA5 || q_fe[0] !== 1'b0 || q_pe[0] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL single_data: got %h fe=%b pe=%b, want a5 fe=0 pe=0",
                         q_data[0], q_fe[0], q_pe[0]);
            end
            // rx_s falls two clocks after the line does.
            delta = q_cyc[0] - (sc + 2);
            tests_run++;
            if (delta < 1518 || delta > 1522) begin
                tests_failed++;
                $display("[TB] FAIL single_latency: got %0d cycles, want 1520+-2", delta);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int sc;
        clear_queues();
        exp.push_back(8'h00); exp.push_back(8'hFF); exp.push_back(8'h3C);
        for (int i = 0; i < 10; i++) exp.push_back(8'($urandom_range(200, 10)));
        foreach (exp[i]) send_frame(0, exp[i], 0, 1'b0, 1'b1, sc);
        repeat (320) @(negedge clk);
        tests_run++;
        if (q_data.size() !== exp.size()) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d rxdone, want %0d", q_data.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests_run++;
            if (i >= q_data.size() || q_data[i] !== exp[i] || q_fe[i] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_byte%0d: got %h, want %h fe=0", i,
                         (i < q_data.size()) ? q_data[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int sc;
        clear_queues();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy_high: got busy=%b, want 1", busy);
        end
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || q_data.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_reject: got busy=%b rxdone=%0d, want busy=0 rxdone=0",
                     busy, q_data.size());
        end
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, sc);
        repeat (40) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 1 || q_data[0] !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL glitch_next_byte: got %0d frames first=%h, want 1 frame 5a",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx);
        end
    endtask

    task automatic test_break();
        int sc;
        clear_queues();
        send_frame(0, 8'h81, 0, 1'b0, 1'b0, sc);
        drive_bit(0, 1'b0, 3000);
        tests_run++;
        if (q_data.size() !== 1 || q_data[0] !== 8'h81 || q_fe[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL break_frame: got %0d frames first=%h fe=%b, want 1 frame 81 fe=1",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx,
                     (q_fe.size() > 0) ? q_fe[0] : 1'b0);
        end
        tests_run++;
        if (frame_err !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL break_hold: got fe=%b busy=%b, want fe=1 busy=1", frame_err, busy);
        end
        drive_bit(0, 1'b1, 320);
        send_frame(0, 8'h42, 0, 1'b0, 1'b1, sc);
        repeat (40) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 2 || q_data[1] !== 8'h42 || q_fe[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL break_recover: got %0d frames, want 2 with last 42 fe=0",
                     q_data.size());
        end
    endtask

    task automatic test_parity();
        logic [7:0] d[$];
        bit         pb[$];
        int sc;
        bit exp_pe;
        clear_queues();
        d.push_back(8'h07); pb.push_back(1'b1);
        d.push_back(8'h07); pb.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            d.push_back(8'($urandom_range(255, 0)));
            pb.push_back(1'($urandom_range(1, 0)));
        end
        foreach (d[i]) send_frame(1, d[i], 1, pb[i], 1'b1, sc);
        repeat (320) @(negedge clk);
        tests_run++;
        if (qp_data.size() !== d.size()) begin
            tests_failed++;
            $display("[TB] FAIL parity_count: got %0d rxdone, want %0d", qp_data.size(), d.size());
        end
        for (int i = 0; i < d.size(); i++) begin
            // Even parity: data ones plus the parity bit must be even.
            exp_pe = ($countones(d[i]) + int'(pb[i])) % 2 != 0;
            tests_run++;
            if (i >= qp_data.size() || qp_data[i] !== d[i] || qp_pe[i] !== exp_pe) begin
                tests_failed++;
                $display("[TB] FAIL parity_frame%0d: got %h pe=%b, want %h pe=%b", i,
                         (i < qp_data.size()) ? qp_data[i] : 8'hxx,
                         (i < qp_pe.size()) ? qp_pe[i] : 1'bx, d[i], exp_pe);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hC3;
        int sc;
        clear_queues();
        drive_bit(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(0, d[i], BIT_CLKS);
        drive_bit(0, d[3], BIT_CLKS / 2);
        // The sender is aborted together with the receiver.
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rxout, rxdone, frame_err, parity_err, busy} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got rxout=%h done=%b fe=%b pe=%b busy=%b, want all 0",
                     rxout, rxdone, frame_err, parity_err, busy);
        end
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_done: got %0d rxdone busy=%b, want 0 and 0",
                     q_data.size(), busy);
        end
        send_frame(0, 8'h99, 0, 1'b0, 1'b1, sc);
        repeat (40) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 1 || q_data[0] !== 8'h99 || q_fe[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next_byte: got %0d frames first=%h, want 1 frame 99",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx);
        end
    endtask

    task automatic test_strobe_width();
        tests_run++;
        if (dbl_strobes !== 0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_width: got %0d back-to-back rxdone cycles, want 0", dbl_strobes);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_parity();
        test_reset_mid_frame();
        test_strobe_width();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone 8N1-class UART receiver with 16x oversampling, for the receive end of the serial link.
- Accepts a line driven by any UART transmitter, including the team's own top-level TX, and recovers each byte.
- Adds mid-bit sampling, false-start rejection, optional parity, and framing/parity error flags with one-cycle done strobes.
- Sits between the serial pin and byte-wide consumer logic.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit; must be even and at least 4.
- DATA_BITS, 8: payload bits per frame, 5..8.
- PARITY_EN, 0: 1 means one parity bit follows the data.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- rxout  out  DATA_BITS  last received byte, LSB = first data bit.
- rxdone  out  1  one-cycle strobe; rxout and the error flags are valid in this cycle.
- frame_err  out  1  stop bit sampled low for the frame just completed.
- parity_err  out  1  parity mismatch for the frame just completed.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; rxout=0, rxdone=0, frame_err=0, parity_err=0, busy=0.
  - Tick counter=0; synchronizer FFs=1.
  - Reset mid-frame aborts the frame with no rxdone.
- Input sync: 2-FF synchronizer rx -> rx_s. All decisions use rx_s.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor.
  - Counter wraps at TICK_DIV-1 and emits tick for 1 cycle at the wrap.
  - Counter is forced to 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rx_s=0 -> START; tick count=0.
- START:
  - After OVERSAMPLE/2 ticks, sample rx_s.
  - Sample 1 -> false start; return to IDLE with no rxdone.
  - Sample 0 -> DATA; bit index=0, tick count=0.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s and shift it into the shift register MSB side.
  - After DATA_BITS samples: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - After OVERSAMPLE ticks, sample rx_s.
  - Compute the error as (XOR of data bits ^ sample ^ PARITY_ODD) != 0.
- STOP:
  - After OVERSAMPLE ticks, sample rx_s.
  - In the same cycle: rxdone=1, rxout=shifted data (always updated, even on error), frame_err=~sample, parity_err=computed error (0 if PARITY_EN=0).
  - Sample 1 -> IDLE.
  - Sample 0 -> BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE.
  - A held-low line produces exactly one rxdone with frame_err=1.
- Flags: frame_err and parity_err hold their values until the next rxdone overwrites them. rxout also holds between frames.
- Timing:
  - Data bit k is sampled (OVERSAMPLE/2 + OVERSAMPLE*(k+1))*TICK_DIV cycles after the first IDLE cycle with rx_s=0.
  - rxdone fires (OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1+PARITY_EN))*TICK_DIV cycles after that cycle, within ±2 cycles.
- Back-to-back frames:
  - The next start bit may begin immediately after the stop-bit midpoint.
  - The FSM returns to IDLE on the STOP sample cycle, so the following falling edge is caught.
- rxdone is never asserted for two consecutive cycles.

Test Plan:
- Bench settings for all scenarios: CLK_FREQ=1_600_000, BAUD=10_000, giving TICK_DIV=10 and 160 clocks per bit. The bench drives rx from a bit-timed model.
- Single byte: send 0xA5 (8N1) -> exactly one rxdone; rxout=0xA5, frame_err=0, parity_err=0. rxdone occurs 1520±2 cycles after the first rx_s low.
- Back-to-back: send 0x00, 0xFF, 0x3C, then 10 random bytes in range 10..200, with zero idle between frames -> rxout matches every byte in order, with one rxdone each.
- Glitch: rx low for 40 clocks, then high -> no rxdone; busy returns to 0. A following byte 0x5A is received correctly.
- Framing/break: send 0x81 with stop bit 0, and hold the line low for 3000 clocks -> one rxdone with frame_err=1, then no further rxdone. After the line returns high, byte 0x42 is received with frame_err=0.
- Parity: PARITY_EN=1, PARITY_ODD=0. Send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1, rxout=0x07.
- Reset mid-frame: assert rst_n=0 for 2 cycles during data bit 3 of 0xC3 -> no rxdone, all outputs 0. A byte 0x99 sent after the line idles is received correctly.
